// File: rtl/output_interface.sv
// output_interface: egress port of the AES engine.
// Captures the 128-bit result on a rising edge of engine_done, then streams it
// out MSB-first, one byte per valid/ack handshake. A result that arrives while
// a frame is still in flight sets the sticky overrun flag and is dropped.
// Optional feature: define OUT_CHECKSUM_EN to append an XOR checksum byte
// after the data bytes.
module output_interface #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DATA_W-1:0] cipher_in,
  input  logic              engine_done,
  output logic [BYTE_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ack,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              overrun
);

  localparam int unsigned NUM_BYTES = DATA_W / BYTE_W;
  localparam int unsigned CNT_W     = $clog2(NUM_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

`ifdef OUT_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shift;
  logic [CNT_W-1:0]  cnt;
  logic              engine_done_q;
  logic              rise;
  logic              last;
`ifdef OUT_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  assign rise = engine_done & ~engine_done_q;
  assign last = (cnt == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and output decode; outputs are pure functions of state/datapath
  always_comb begin
    state_nxt  = state;
    dout       = '0;
    dout_valid = 1'b0;
    tx_busy    = 1'b0;
    tx_done    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_nxt = SEND;
      end
      SEND: begin
        dout       = shift[DATA_W-1 -: BYTE_W];
        dout_valid = 1'b1;
        tx_busy    = 1'b1;
`ifdef OUT_CHECKSUM_EN
        if (dout_ack && last) state_nxt = CSUM;
`else
        if (dout_ack && last) state_nxt = DONE;
`endif
      end
`ifdef OUT_CHECKSUM_EN
      CSUM: begin
        dout       = csum;
        dout_valid = 1'b1;
        tx_busy    = 1'b1;
        if (dout_ack) state_nxt = DONE;
      end
`endif
      DONE: begin
        tx_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: edge-detect register, capture, shift-out and byte counter
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      engine_done_q <= 1'b0;
      shift         <= '0;
      cnt           <= '0;
`ifdef OUT_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      engine_done_q <= engine_done;
      if (state == IDLE && rise) begin
        shift <= cipher_in;
        cnt   <= '0;
`ifdef OUT_CHECKSUM_EN
        csum  <= '0;
`endif
      end else if (state == SEND && dout_ack) begin
        shift <= shift << BYTE_W;
        if (!last) cnt <= cnt + CNT_W'(1);
`ifdef OUT_CHECKSUM_EN
        csum  <= csum ^ shift[DATA_W-1 -: BYTE_W];
`endif
      end
    end
  end

  // Sticky overrun: any result rise outside IDLE is dropped and flagged
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                     overrun <= 1'b0;
    else if (rise && state != IDLE) overrun <= 1'b1;
  end

endmodule

// File: tb/tb_output_interface.sv
// Scoreboard bench for output_interface: stimulus pushes expected bytes,
// a negedge monitor pops and compares on every valid&ack transfer.
module tb_output_interface;

`ifdef OUT_CHECKSUM_EN
  localparam int NB_TX = 17;
`else
  localparam int NB_TX = 16;
`endif

  logic         clk = 1'b0;
  logic         rst_ = 1'b0;
  logic [127:0] cipher_in = '0;
  logic         engine_done = 1'b0;
  logic [7:0]   dout;
  logic         dout_valid;
  logic         dout_ack = 1'b0;
  logic         tx_busy;
  logic         tx_done;
  logic         overrun;

  int tests = 0;
  int fails = 0;
  int done_pulses = 0;
  logic [7:0] exp_q[$];

  output_interface #(.DATA_W(128), .BYTE_W(8)) dut (
    .clk(clk), .rst_(rst_), .cipher_in(cipher_in), .engine_done(engine_done),
    .dout(dout), .dout_valid(dout_valid), .dout_ack(dout_ack),
    .tx_busy(tx_busy), .tx_done(tx_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every handshake must match the head of the scoreboard
  always @(negedge clk) begin
    if (dout_valid && dout_ack) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL byte_unexpected: got %0h expected none", dout);
      end else begin
        check("byte", {24'h0, dout}, {24'h0, exp_q.pop_front()});
      end
    end
    if (tx_done) done_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [127:0] d);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(d[127-8*i -: 8]);
      x = x ^ d[127-8*i -: 8];
    end
`ifdef OUT_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // Raise engine_done; on return byte 0 is being presented
  task automatic start(input logic [127:0] d);
    engine_done = 1'b0;
    tick();
    cipher_in   = d;
    engine_done = 1'b1;
    push_frame(d);
    tick();
    cipher_in = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
  endtask

  // Count negedges until tx_done; bounded
  task automatic wait_done(input int exp_cycles, input string name);
    int  c;
    bit  seen;
    c = 0;
    seen = 0;
    while (c < 200 && !seen) begin
      @(negedge clk);
      c++;
      if (tx_done) seen = 1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no tx_done expected tx_done", name);
    end else begin
      check(name, c, exp_cycles);
      check({name, "_valid_in_done"}, {31'h0, dout_valid}, 0);
      check({name, "_dout_in_done"}, {24'h0, dout}, 0);
    end
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    // Reset state
    #3;
    check("rst_valid", {31'h0, dout_valid}, 0);
    check("rst_dout", {24'h0, dout}, 0);
    check("rst_busy", {31'h0, tx_busy}, 0);
    check("rst_done", {31'h0, tx_done}, 0);
    check("rst_overrun", {31'h0, overrun}, 0);
    tick();
    rst_ = 1'b1;
    tick();

    // Full frame, ack tied high, engine_done held high afterwards
    dout_ack = 1'b1;
    start(128'h3925841d02dc09fbdc118597196a0b32);
    check("latency_valid", {31'h0, dout_valid}, 1);
    check("first_byte", {24'h0, dout}, 32'h39);
    wait_done(NB_TX + 1, "frame_len");
    repeat (4) tick();
    check("held_done_no_recapture", {31'h0, dout_valid}, 0);
    check("no_overrun_yet", {31'h0, overrun}, 0);

    // Backpressure on the 09 byte
    start(128'h3925841d02dc09fbdc118597196a0b32);
    engine_done = 1'b0;
    repeat (6) tick();
    dout_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_dout", {24'h0, dout}, 32'h09);
      check("hold_valid", {31'h0, dout_valid}, 1);
      check("hold_busy", {31'h0, tx_busy}, 1);
      tick();
    end
    dout_ack = 1'b1;
    wait_done(NB_TX - 6 + 1, "hold_frame_len");

    // Second rise during byte 8 -> overrun, frame unaffected
    start(128'h3925841d02dc09fbdc118597196a0b32);
    engine_done = 1'b0;
    repeat (8) tick();
    cipher_in   = 128'h11111111_22222222_33333333_44444444;
    engine_done = 1'b1;
    tick();
    check("overrun_set", {31'h0, overrun}, 1);
    wait_done(NB_TX - 8, "overrun_frame_len");
    repeat (5) tick();
    check("no_second_frame", {31'h0, dout_valid}, 0);
    check("overrun_sticky", {31'h0, overrun}, 1);

    // Reset after 7 transfers aborts the frame
    start(128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
    repeat (7) tick();
    check("pre_rst_dout", {24'h0, dout}, 32'ha7);
    rst_ = 1'b0;
    engine_done = 1'b0;
    #1;
    check("async_rst_valid", {31'h0, dout_valid}, 0);
    check("async_rst_dout", {24'h0, dout}, 0);
    check("async_rst_busy", {31'h0, tx_busy}, 0);
    check("async_rst_overrun", {31'h0, overrun}, 0);
    exp_q.delete();
    snap = done_pulses;
    repeat (2) tick();
    rst_ = 1'b1;
    repeat (3) tick();
    check("no_done_after_abort", done_pulses, snap);
    start(128'h00112233445566778899aabbccddeeff);
    check("restart_byte0", {24'h0, dout}, 32'h00);
    wait_done(NB_TX + 1, "restart_frame_len");

    // Ascending pattern; checksum byte is 8'h10 when enabled
    start(128'h0102030405060708090a0b0c0d0e0f10);
    engine_done = 1'b0;
    wait_done(NB_TX + 1, "csum_frame_len");
    check("scoreboard_empty", exp_q.size(), 0);
    check("overrun_final", {31'h0, overrun}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
